// File: rtl/tx_drain_scheduler_pkg.sv
// Shared types and default sizing for the transmit drain scheduler.
// Optional per-source byte counters are enabled by TX_DRAIN_STATS_EN.
package tx_sched_pkg;

   localparam int ADDR_W_DEF    = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int BURST_MAX_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      XFER    = 2'd3
   } sched_state_t;

   typedef enum logic {
      SRC_MEM1 = 1'b0,
      SRC_MEM2 = 1'b1
   } src_t;

endpackage

// File: rtl/tx_drain_scheduler_if.sv
// Byte-stream valid/ready bundle between the scheduler and the consumer.
interface tx_drain_scheduler_if #(
   parameter int DATA_W = 8
);

   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_src,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_src,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/tx_drain_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; last grant moves only on a take strobe.
module rr_arbiter2
   import tx_sched_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic req1,
   input  logic req2,
   input  logic take,
   output logic gnt_vld,
   output src_t gnt
);

   src_t last_q;
   src_t last_d;

   always_comb begin
      gnt_vld = req1 | req2;
      gnt     = SRC_MEM1;
      priority case (1'b1)
         (req1 && req2): gnt = (last_q == SRC_MEM1) ? SRC_MEM2 : SRC_MEM1;
         req1:           gnt = SRC_MEM1;
         req2:           gnt = SRC_MEM2;
         default:        gnt = SRC_MEM1;
      endcase
      last_d = last_q;
      if (take && gnt_vld) last_d = gnt;
   end

   // Reset to mem2 so mem1 wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) last_q <= SRC_MEM2;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/tx_drain_scheduler.sv
// Drains two transmit memories through their read ports into one byte stream.
// Define TX_DRAIN_STATS_EN to add saturating per-source byte counters.
module tx_drain_scheduler
   import tx_sched_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W:0]   mem1_wr_ptr,
   input  logic [ADDR_W:0]   mem2_wr_ptr,
   output logic [ADDR_W:0]   mem1_rd_ptr,
   output logic [ADDR_W:0]   mem2_rd_ptr,
   output logic              mem1_renb,
   output logic [ADDR_W-1:0] mem1_addrb,
   input  logic [DATA_W-1:0] mem1_doutb,
   output logic              mem2_renb,
   output logic [ADDR_W-1:0] mem2_addrb,
   input  logic [DATA_W-1:0] mem2_doutb,
   tx_drain_scheduler_if.master bus,
   output logic              busy,
   output logic [2:0]        sched_state
`ifdef TX_DRAIN_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [15:0]       mem1_byte_cnt,
   output logic [15:0]       mem2_byte_cnt
`endif
);

   localparam int PW = ADDR_W + 1;
   localparam int CW = ADDR_W + 1;

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_READ    = READ;
   localparam logic [1:0] S_CAPTURE = CAPTURE;
   localparam logic [1:0] S_XFER    = XFER;

   localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

   logic [1:0]        state_q, state_d;
   src_t              src_q, src_d;
   logic [CW-1:0]     burst_q, burst_d;
   logic [PW-1:0]     rd1_q, rd1_d;
   logic [PW-1:0]     rd2_q, rd2_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              osrc_q, osrc_d;

   logic [PW-1:0] avail1;
   logic [PW-1:0] avail2;
   logic [PW-1:0] avail_cur;
   logic [CW-1:0] burst_inc;
   logic          take;
   logic          gnt_vld;
   src_t          gnt;
   logic          hs;

   assign avail1    = mem1_wr_ptr - rd1_q;
   assign avail2    = mem2_wr_ptr - rd2_q;
   assign avail_cur = (src_q == SRC_MEM2) ? avail2 : avail1;
   assign burst_inc = burst_q + CW'(1);
   assign hs        = (state_q == S_XFER) && bus.out_ready;

   rr_arbiter2 u_arb (
      .clock   (clock),
      .reset   (reset),
      .req1    (avail1 != '0),
      .req2    (avail2 != '0),
      .take    (take),
      .gnt_vld (gnt_vld),
      .gnt     (gnt)
   );

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      burst_d   = burst_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      data_d    = data_q;
      osrc_d    = osrc_q;
      take      = 1'b0;
      mem1_renb = 1'b0;
      mem2_renb = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable && gnt_vld) begin
               take    = 1'b1;
               src_d   = gnt;
               burst_d = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (src_q == SRC_MEM2) mem2_renb = 1'b1;
            else                   mem1_renb = 1'b1;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            data_d  = (src_q == SRC_MEM2) ? mem2_doutb : mem1_doutb;
            osrc_d  = src_q;
            state_d = S_XFER;
         end
         S_XFER: begin
            if (bus.out_ready) begin
               if (src_q == SRC_MEM2) rd2_d = rd2_q + PW'(1);
               else                   rd1_d = rd1_q + PW'(1);
               burst_d = burst_inc;
               // Live wr_ptr feeds avail, so fresh writes can stretch the burst.
               if (enable && (burst_inc < BMAX) && (avail_cur > PW'(1)))
                  state_d = S_READ;
               else
                  state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         src_q   <= SRC_MEM1;
         burst_q <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         data_q  <= '0;
         osrc_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         burst_q <= burst_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         data_q  <= data_d;
         osrc_q  <= osrc_d;
      end
   end

   assign mem1_addrb    = mem1_renb ? rd1_q[ADDR_W-1:0] : '0;
   assign mem2_addrb    = mem2_renb ? rd2_q[ADDR_W-1:0] : '0;
   assign mem1_rd_ptr   = rd1_q;
   assign mem2_rd_ptr   = rd2_q;
   assign bus.out_data  = data_q;
   assign bus.out_src   = osrc_q;
   assign bus.out_valid = (state_q == S_XFER);
   assign busy          = (state_q != S_IDLE);
   assign sched_state   = {1'b0, state_q};

`ifdef TX_DRAIN_STATS_EN
   logic [15:0] cnt1_q, cnt1_d;
   logic [15:0] cnt2_q, cnt2_d;

   always_comb begin
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (stats_clr) begin
         cnt1_d = '0;
         cnt2_d = '0;
      end else if (hs) begin
         if (osrc_q && (cnt2_q != 16'hFFFF))  cnt2_d = cnt2_q + 16'd1;
         if (!osrc_q && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   assign mem1_byte_cnt = cnt1_q;
   assign mem2_byte_cnt = cnt2_q;
`else
   logic unused_hs;
   assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_tx_drain_scheduler.sv
// Scoreboard bench for tx_drain_scheduler with behavioural port-B memories.
// Stats checks compile in when TX_DRAIN_STATS_EN is defined.
module tb_tx_drain_scheduler;
   import tx_sched_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int PW = AW + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [PW-1:0] mem1_wr_ptr = '0;
   logic [PW-1:0] mem2_wr_ptr = '0;
   logic [PW-1:0] mem1_rd_ptr;
   logic [PW-1:0] mem2_rd_ptr;
   logic          mem1_renb;
   logic          mem2_renb;
   logic [AW-1:0] mem1_addrb;
   logic [AW-1:0] mem2_addrb;
   logic [DW-1:0] mem1_doutb = '0;
   logic [DW-1:0] mem2_doutb = '0;
   logic          busy;
   logic [2:0]    sched_state;
`ifdef TX_DRAIN_STATS_EN
   logic          stats_clr = 1'b0;
   logic [15:0]   mem1_byte_cnt;
   logic [15:0]   mem2_byte_cnt;
`endif

   always #5 clock = ~clock;

   tx_drain_scheduler_if #(.DATA_W(DW)) bus ();

   tx_drain_scheduler #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .mem1_wr_ptr (mem1_wr_ptr),
      .mem2_wr_ptr (mem2_wr_ptr),
      .mem1_rd_ptr (mem1_rd_ptr),
      .mem2_rd_ptr (mem2_rd_ptr),
      .mem1_renb   (mem1_renb),
      .mem1_addrb  (mem1_addrb),
      .mem1_doutb  (mem1_doutb),
      .mem2_renb   (mem2_renb),
      .mem2_addrb  (mem2_addrb),
      .mem2_doutb  (mem2_doutb),
      .bus         (bus.master),
      .busy        (busy),
      .sched_state (sched_state)
`ifdef TX_DRAIN_STATS_EN
      ,
      .stats_clr     (stats_clr),
      .mem1_byte_cnt (mem1_byte_cnt),
      .mem2_byte_cnt (mem2_byte_cnt)
`endif
   );

   logic [DW-1:0] m1 [16];
   logic [DW-1:0] m2 [16];

   always @(posedge clock) begin
      if (mem1_renb) mem1_doutb <= m1[mem1_addrb];
      if (mem2_renb) mem2_doutb <= m2[mem2_addrb];
   end

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q1 [$];
   logic [DW-1:0] q2 [$];
   logic          src_log [$];
   logic [AW-1:0] addr_log [$];
   logic [DW-1:0] mon_exp;

   // Consumer-side scoreboard: every accepted byte must match its source queue.
   always @(negedge clock) begin
      if (!reset) begin
         if (mem1_renb) addr_log.push_back(mem1_addrb);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            src_log.push_back(bus.out_src);
            if ((bus.out_src ? q2.size() : q1.size()) == 0) begin
               errors++;
               $display("FAIL byte_unexpected src=%0d got=%h required=none",
                        bus.out_src, bus.out_data);
            end else begin
               mon_exp = bus.out_src ? q2.pop_front() : q1.pop_front();
               if (bus.out_data !== mon_exp) begin
                  errors++;
                  $display("FAIL byte_data src=%0d got=%h required=%h",
                           bus.out_src, bus.out_data, mon_exp);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic s, input logic [DW-1:0] d);
      if (!s) begin
         m1[mem1_wr_ptr[AW-1:0]] = d;
         mem1_wr_ptr = mem1_wr_ptr + PW'(1);
         q1.push_back(d);
      end else begin
         m2[mem2_wr_ptr[AW-1:0]] = d;
         mem2_wr_ptr = mem2_wr_ptr + PW'(1);
         q2.push_back(d);
      end
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      mem1_wr_ptr = '0;
      mem2_wr_ptr = '0;
      q1.delete();
      q2.delete();
      src_log.delete();
      addr_log.delete();
      bus.out_ready = 1'b1;
      enable = 1'b1;
      repeat (2) step();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (!(sched_state == 3'd0 && mem1_rd_ptr == mem1_wr_ptr &&
               mem2_rd_ptr == mem2_wr_ptr) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout rd1=%0d wr1=%0d rd2=%0d wr2=%0d",
                  mem1_rd_ptr, mem1_wr_ptr, mem2_rd_ptr, mem2_wr_ptr);
      end
      checks++;
      if (q1.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL drain_leftover got=%0d/%0d required=0/0",
                  q1.size(), q2.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_src, mem1_rd_ptr, mem2_rd_ptr,
           mem1_renb, mem2_renb, mem1_addrb, mem2_addrb, busy,
           sched_state} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h s=%b r1=%0d r2=%0d st=%0d required=all0",
                  bus.out_valid, bus.out_data, bus.out_src, mem1_rd_ptr,
                  mem2_rd_ptr, sched_state);
      end
   endtask

   task automatic test_single();
      do_reset();
      push(1'b0, 8'hA5);
      step();
      checks++;
      if (mem1_renb !== 1'b1 || mem1_addrb !== 4'd0 || mem2_renb !== 1'b0) begin
         errors++;
         $display("FAIL single_read got renb1=%b addr=%0d renb2=%b required=1/0/0",
                  mem1_renb, mem1_addrb, mem2_renb);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || sched_state !== 3'd2 || mem1_renb !== 1'b0) begin
         errors++;
         $display("FAIL single_capture got v=%b st=%0d required=0/2",
                  bus.out_valid, sched_state);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_src !== 1'b0) begin
         errors++;
         $display("FAIL single_xfer got v=%b d=%h s=%b required=1/a5/0",
                  bus.out_valid, bus.out_data, bus.out_src);
      end
      step();
      checks++;
      if (mem1_rd_ptr !== 5'd1 || sched_state !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_done got rd1=%0d st=%0d v=%b required=1/0/0",
                  mem1_rd_ptr, sched_state, bus.out_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [8:0] exp_v;
      logic [8:0] got_v;
      do_reset();
      for (int i = 0; i < 6; i++) push(1'b0, 8'h10 + 8'(i));
      for (int i = 0; i < 3; i++) push(1'b1, 8'h20 + 8'(i));
      wait_drain(300);
      exp_v = 9'b001110000;
      got_v = '0;
      for (int i = 0; i < 9 && i < src_log.size(); i++) got_v[i] = src_log[i];
      checks++;
      if (src_log.size() != 9 || got_v !== exp_v) begin
         errors++;
         $display("FAIL rr_order got n=%0d %b required n=9 %b",
                  src_log.size(), got_v, exp_v);
      end
      checks++;
      if (mem1_rd_ptr !== 5'd6 || mem2_rd_ptr !== 5'd3) begin
         errors++;
         $display("FAIL rr_ptrs got %0d/%0d required 6/3",
                  mem1_rd_ptr, mem2_rd_ptr);
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [DW-1:0] held;
      do_reset();
      bus.out_ready = 1'b0;
      push(1'b1, 8'h3C);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL bp_valid_timeout got v=%b required=1", bus.out_valid);
      end
      held = 8'h3C;
      repeat (10) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== held ||
             mem1_renb !== 1'b0 || mem2_renb !== 1'b0 || mem2_rd_ptr !== 5'd0) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%h rd2=%0d required=1/%h/0",
                     bus.out_valid, bus.out_data, mem2_rd_ptr, held);
         end
      end
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (mem2_rd_ptr !== 5'd1 || bus.out_valid !== 1'b0 || q2.size() != 0) begin
         errors++;
         $display("FAIL bp_accept got rd2=%0d v=%b required=1/0",
                  mem2_rd_ptr, bus.out_valid);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] got_a;
      do_reset();
      for (int i = 0; i < 14; i++) push(1'b0, 8'(i));
      wait_drain(300);
      addr_log.delete();
      for (int i = 0; i < 4; i++) push(1'b0, 8'hB0 + 8'(i));
      wait_drain(100);
      got_a = '0;
      for (int i = 0; i < 4 && i < addr_log.size(); i++) got_a[i*4 +: 4] = addr_log[i];
      checks++;
      if (addr_log.size() != 4 || got_a !== 16'h10FE) begin
         errors++;
         $display("FAIL wrap_addrs got n=%0d %h required n=4 10fe",
                  addr_log.size(), got_a);
      end
      checks++;
      if (mem1_rd_ptr !== 5'd18) begin
         errors++;
         $display("FAIL wrap_ptr got %0d required 18", mem1_rd_ptr);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      for (int i = 0; i < 3; i++) push(1'b0, 8'hC0 + 8'(i));
      n = 0;
      while (sched_state !== 3'd2 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL rst_mid_no_capture got st=%0d required=2", sched_state);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || sched_state !== 3'd0 ||
          mem1_rd_ptr !== 5'd0 || bus.out_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_async got v=%b st=%0d rd1=%0d d=%h required=0/0/0/00",
                  bus.out_valid, sched_state, mem1_rd_ptr, bus.out_data);
      end
      repeat (5) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b0 || mem1_renb !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_held got v=%b renb=%b busy=%b required=0/0/0",
                     bus.out_valid, mem1_renb, busy);
         end
      end
      mem1_wr_ptr = '0;
      q1.delete();
      reset = 1'b0;
      repeat (8) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after got v=%b busy=%b required=0/0",
                     bus.out_valid, busy);
         end
      end
   endtask

   task automatic test_enable();
      do_reset();
      enable = 1'b0;
      push(1'b0, 8'h77);
      repeat (10) begin
         step();
         checks++;
         if (mem1_renb !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_off got renb=%b busy=%b required=0/0",
                     mem1_renb, busy);
         end
      end
      enable = 1'b1;
      wait_drain(50);
   endtask

   task automatic test_extend();
      do_reset();
      push(1'b0, 8'h51);
      step();
      push(1'b0, 8'h52);
      push(1'b0, 8'h53);
      wait_drain(60);
      checks++;
      if (src_log.size() != 3 || mem1_rd_ptr !== 5'd3) begin
         errors++;
         $display("FAIL extend got n=%0d rd1=%0d required 3/3",
                  src_log.size(), mem1_rd_ptr);
      end
   endtask

`ifdef TX_DRAIN_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 5; i++) push(1'b1, 8'h60 + 8'(i));
      wait_drain(100);
      checks++;
      if (mem2_byte_cnt !== 16'd5 || mem1_byte_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stats_count got %0d/%0d required 0/5",
                  mem1_byte_cnt, mem2_byte_cnt);
      end
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      checks++;
      if (mem2_byte_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stats_clr got %0d required 0", mem2_byte_cnt);
      end
   endtask
`endif

   initial begin
      bus.out_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_enable();
      test_extend();
`ifdef TX_DRAIN_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1);
   end

endmodule
